// File: rtl/clint_if.sv
// Bus bundle between the core pipeline/CSR block and the core-local interrupt controller.
// The master side drives decode/EX/CSR state; the slave side (clint) returns CSR writes and redirects.
interface clint_if #(
  parameter int DW = 16
);
  logic          inst_ecall;
  logic          inst_ebreak;
  logic          inst_mret;
  logic [DW-1:0] inst_addr;
  logic          ex_jump;
  logic [DW-1:0] ex_jump_addr;
  logic          ex_busy;
  logic          ex_csr_we;
  logic          irq_ext;
  logic          irq_tmr;
  logic [DW-1:0] csr_mtvec;
  logic [DW-1:0] csr_mepc;
  logic [DW-1:0] csr_mstatus;
  logic          global_int_en;
  logic [2:0]    int_we;
  logic [DW-1:0] int_mepc;
  logic [DW-1:0] int_mcause;
  logic [DW-1:0] int_mstatus;
  logic          hold_o;
  logic          int_assert;
  logic [DW-1:0] int_addr;

  modport master (
    output inst_ecall, inst_ebreak, inst_mret, inst_addr, ex_jump, ex_jump_addr,
           ex_busy, ex_csr_we, irq_ext, irq_tmr, csr_mtvec, csr_mepc, csr_mstatus,
           global_int_en,
    input  int_we, int_mepc, int_mcause, int_mstatus, hold_o, int_assert, int_addr
  );

  modport slave (
    input  inst_ecall, inst_ebreak, inst_mret, inst_addr, ex_jump, ex_jump_addr,
           ex_busy, ex_csr_we, irq_ext, irq_tmr, csr_mtvec, csr_mepc, csr_mstatus,
           global_int_en,
    output int_we, int_mepc, int_mcause, int_mstatus, hold_o, int_assert, int_addr
  );
endinterface

// File: rtl/clint.sv
// Core-local trap/interrupt controller: accepts ecall/ebreak/mret/irqs, stalls the pipeline,
// writes mepc/mcause/mstatus to the CSR block, then redirects fetch to mtvec or mepc.
module clint #(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  clint_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    JUMP  = 2'd2
  } state_e;

  localparam logic [DW-1:0] CAUSE_ECALL  = DW'(11);
  localparam logic [DW-1:0] CAUSE_EBREAK = DW'(3);
  localparam logic [DW-1:0] CAUSE_EXT    = {1'b1, (DW-1)'(11)};
  localparam logic [DW-1:0] CAUSE_TMR    = {1'b1, (DW-1)'(7)};

  state_e                 state_q, state_d;
  logic                   is_mret_q, is_mret_d;
  logic [DW-1:0]          cause_q, cause_d;
  logic [DW-1:0]          epc_q, epc_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
  logic [SYNC_STAGES-1:0] tmr_sync_q, tmr_sync_d;

  logic          irq_ext_s, irq_tmr_s;
  logic          req_ok, irq_ok;
  logic [DW-1:0] trap_mstatus, mret_mstatus, irq_epc;

  always_comb begin
    ext_sync_d = {ext_sync_q[SYNC_STAGES-2:0], bus.irq_ext};
    tmr_sync_d = {tmr_sync_q[SYNC_STAGES-2:0], bus.irq_tmr};
  end

  assign irq_ext_s = ext_sync_q[SYNC_STAGES-1];
  assign irq_tmr_s = tmr_sync_q[SYNC_STAGES-1];

  // Gating on rst_n keeps hold_o low while reset is held, whatever the pipeline presents.
  assign req_ok  = rst_n & ~bus.ex_busy;
  assign irq_ok  = req_ok & bus.global_int_en;
  assign irq_epc = bus.ex_jump ? bus.ex_jump_addr : bus.inst_addr;

  // Trap: MPIE <- MIE, MIE <- 0.  mret: MIE <- MPIE, MPIE <- 1.
  always_comb begin
    trap_mstatus    = bus.csr_mstatus;
    trap_mstatus[7] = bus.csr_mstatus[3];
    trap_mstatus[3] = 1'b0;
    mret_mstatus    = bus.csr_mstatus;
    mret_mstatus[3] = bus.csr_mstatus[7];
    mret_mstatus[7] = 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    is_mret_d       = is_mret_q;
    cause_d         = cause_q;
    epc_d           = epc_q;
    bus.hold_o      = 1'b0;
    bus.int_we      = 3'b000;
    bus.int_mepc    = '0;
    bus.int_mcause  = '0;
    bus.int_mstatus = '0;
    bus.int_assert  = 1'b0;
    bus.int_addr    = '0;

    unique case (state_q)
      IDLE: begin
        if (req_ok && (bus.inst_ecall || bus.inst_ebreak)) begin
          state_d    = WRITE;
          is_mret_d  = 1'b0;
          cause_d    = bus.inst_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          epc_d      = bus.inst_addr;
          bus.hold_o = 1'b1;
        end else if (req_ok && bus.inst_mret) begin
          state_d    = WRITE;
          is_mret_d  = 1'b1;
          cause_d    = '0;
          epc_d      = '0;
          bus.hold_o = 1'b1;
        end else if (irq_ok && irq_ext_s) begin
          state_d    = WRITE;
          is_mret_d  = 1'b0;
          cause_d    = CAUSE_EXT;
          epc_d      = irq_epc;
          bus.hold_o = 1'b1;
        end else if (irq_ok && irq_tmr_s) begin
          state_d    = WRITE;
          is_mret_d  = 1'b0;
          cause_d    = CAUSE_TMR;
          epc_d      = irq_epc;
          bus.hold_o = 1'b1;
        end
      end

      WRITE: begin
        bus.hold_o = 1'b1;
        if (is_mret_q) begin
          bus.int_mstatus = mret_mstatus;
        end else begin
          bus.int_mepc    = epc_q;
          bus.int_mcause  = cause_q;
          bus.int_mstatus = trap_mstatus;
        end
        // The CSR block gives EX writes priority; retry until the port is free.
        if (!bus.ex_csr_we) begin
          bus.int_we = is_mret_q ? 3'b001 : 3'b111;
          state_d    = JUMP;
        end
      end

      JUMP: begin
        bus.hold_o     = 1'b1;
        bus.int_assert = 1'b1;
        bus.int_addr   = is_mret_q ? bus.csr_mepc : bus.csr_mtvec;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_mret_q  <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
      ext_sync_q <= '0;
      tmr_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      is_mret_q  <= is_mret_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      ext_sync_q <= ext_sync_d;
      tmr_sync_q <= tmr_sync_d;
    end
  end

endmodule
